// File: rtl/tune_player.sv
// tune_player: ROM-driven melody sequencer for the buzzer game.
// Fetches {half_period,dur} words and drives a square-wave buzzer.
module tune_player #(
  parameter int NUM_LEVELS = 4,
  parameter int SEQ_LEN    = 16,
  parameter int DIV_W      = 16,
  parameter int DUR_W      = 8,
  parameter int TICK_CYC   = 250000,
  parameter int GAP_CYC    = 50000,
  localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LVL_W-1:0]       level_sel,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  output logic [LVL_W+IDX_W-1:0] rom_addr,
  input  logic [DIV_W+DUR_W-1:0] rom_data,
  output logic                   buzz,
  output logic                   playing,
  output logic                   done,
  output logic [IDX_W-1:0]       note_idx
);

  localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'(GAP_LAST);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SEQ_LEN - 1);
  localparam logic [LVL_W:0]    LVL_LIM   = (LVL_W+1)'(NUM_LEVELS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LVL_W-1:0]       r_lvl;
  logic [IDX_W-1:0]       r_idx;
  logic [LVL_W+IDX_W-1:0] r_addr;
  logic                   r_done;
  logic                   r_buzz;
  logic [DIV_W-1:0]       r_hp;
  logic [DIV_W-1:0]       r_ph;
  logic [DUR_W-1:0]       r_dur;
  logic [DUR_W-1:0]       r_dcnt;
  logic [TICK_W-1:0]      r_tick;
  logic [GAP_W-1:0]       r_gap;

  logic [DIV_W-1:0] w_rom_hp;
  logic [DUR_W-1:0] w_rom_dur;
  logic             w_lvl_ok;
  logic             w_play_end;
  logic             w_gap_end;
  logic             w_adv;
  logic             w_end;
  logic             w_load;
  logic             w_done_nxt;
  logic [LVL_W-1:0] w_lvl_nxt;
  logic [IDX_W-1:0] w_idx_nxt;

  assign w_rom_hp  = rom_data[DIV_W+DUR_W-1:DUR_W];
  assign w_rom_dur = rom_data[DUR_W-1:0];
  assign w_lvl_ok  = ({1'b0, level_sel} < LVL_LIM);

  assign w_play_end = (r_tick == TICK_LAST) &&
                      (r_dcnt == r_dur - DUR_W'(1));
  assign w_gap_end  = (r_gap == GAP_END);

  assign rom_addr = r_addr;
  assign buzz     = r_buzz;
  assign done     = r_done;
  assign note_idx = r_idx;
  assign playing  = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state, slot advance, end-of-tune and stop handling
  always_comb begin
    w_next     = r_state;
    w_lvl_nxt  = r_lvl;
    w_idx_nxt  = r_idx;
    w_done_nxt = 1'b0;
    w_load     = 1'b0;
    w_adv      = 1'b0;
    w_end      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !stop && w_lvl_ok) begin
          w_next    = S_FETCH;
          w_lvl_nxt = level_sel;
          w_idx_nxt = '0;
        end
      end
      S_FETCH: w_next = S_WAIT;
      S_WAIT: begin
        if (w_rom_dur == '0) begin
          w_end = 1'b1;
        end else begin
          w_next = S_PLAY;
          w_load = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_play_end) begin
          if (GAP_CYC == 0) w_adv = 1'b1;
          else              w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (w_gap_end) w_adv = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_adv) begin
      if (r_idx < IDX_LAST) begin
        w_idx_nxt = r_idx + IDX_W'(1);
        w_next    = S_FETCH;
      end else begin
        w_end = 1'b1;
      end
    end
    if (w_end) begin
      if (loop_en) begin
        w_idx_nxt = '0;
        w_next    = S_FETCH;
      end else begin
        w_done_nxt = 1'b1;
        w_next     = S_IDLE;
      end
    end
    if (stop && (r_state != S_IDLE)) begin
      w_next     = S_IDLE;
      w_idx_nxt  = r_idx;
      w_done_nxt = 1'b0;
      w_load     = 1'b0;
    end
  end

  // Latched level, slot index, registered ROM address and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl  <= '0;
      r_idx  <= '0;
      r_addr <= '0;
      r_done <= 1'b0;
    end else begin
      r_lvl  <= w_lvl_nxt;
      r_idx  <= w_idx_nxt;
      r_done <= w_done_nxt;
      if (w_next == S_FETCH) r_addr <= {w_lvl_nxt, w_idx_nxt};
    end
  end

  // Note timing: tempo ticks, duration, square-wave phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hp   <= '0;
      r_ph   <= '0;
      r_dur  <= '0;
      r_dcnt <= '0;
      r_tick <= '0;
      r_buzz <= 1'b0;
    end else if (w_load) begin
      r_hp   <= w_rom_hp;
      r_dur  <= w_rom_dur;
      r_ph   <= '0;
      r_dcnt <= '0;
      r_tick <= '0;
      r_buzz <= (w_rom_hp != '0);
    end else if (r_state == S_PLAY && w_next == S_PLAY) begin
      if (r_tick == TICK_LAST) begin
        r_tick <= '0;
        r_dcnt <= r_dcnt + DUR_W'(1);
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end
      if (r_hp != '0) begin
        if (r_ph == r_hp - DIV_W'(1)) begin
          r_ph   <= '0;
          r_buzz <= ~r_buzz;
        end else begin
          r_ph <= r_ph + DIV_W'(1);
        end
      end
    end else begin
      r_buzz <= 1'b0;
    end
  end

  // Silent gap counter after each note
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap <= '0;
    end else if (r_state == S_GAP && w_next == S_GAP) begin
      r_gap <= r_gap + GAP_W'(1);
    end else begin
      r_gap <= '0;
    end
  end

endmodule

// File: doc/tune_player.md
# tune_player

Parametrised melody sequencer for the buzzer game. It plays one of `NUM_LEVELS` stored tunes, reading note words from an external synchronous ROM, and generates the square-wave buzzer output. Tempo, note gaps and optional looping are supported. The selected level is latched at start, so the output never glitches when the selector changes. It sits between the level-select logic and the buzzer pin and replaces per-level note generators feeding a combinational output mux.

## Interface
- `NUM_LEVELS`, 4: number of tunes; `LVL_W = max(1, clog2(NUM_LEVELS))`
- `SEQ_LEN`, 16: note slots per tune; `IDX_W = max(1, clog2(SEQ_LEN))`
- `DIV_W`, 16: width of the half-period field, in clk cycles
- `DUR_W`, 8: width of the duration field, in tempo ticks
- `TICK_CYC`, 250000: clk cycles per tempo tick (≥1)
- `GAP_CYC`, 50000: silent clk cycles after each note (0 = no gap)

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `level_sel` in LVL_W: tune to play; sampled only on an accepted `start`
- `start` in 1: start pulse; honoured only in IDLE
- `stop` in 1: abort playback; has priority over `start`
- `loop_en` in 1: sampled at end of tune; 1 = restart from slot 0
- `rom_addr` out LVL_W+IDX_W: `{level, idx}`
- `rom_data` in DIV_W+DUR_W: `{half_period, dur}`; valid 1 cycle after `rom_addr`
- `buzz` out 1: square-wave buzzer drive
- `playing` out 1: high in FETCH/WAIT/PLAY/GAP
- `done` out 1: one-cycle pulse on a non-looped end of tune
- `note_idx` out IDX_W: current slot index

## Operation
FSM states: IDLE, FETCH, WAIT, PLAY, GAP.

- **IDLE**
  - `start`=1, `stop`=0 and `level_sel` < `NUM_LEVELS`: latch the level, set idx=0, go to FETCH.
  - An out-of-range `level_sel` ignores `start`.
- **FETCH**: drive `rom_addr={level,idx}`; go to WAIT.
- **WAIT**: capture `rom_data`.
  - dur==0 is the end marker: go to end-handling.
  - Otherwise load the half-period and duration; go to PLAY.
- **PLAY**
  - hp≠0: `buzz`=1 on entry. A phase counter counts 0..hp-1; `buzz` toggles at the wrap.
  - hp==0 is a rest: `buzz`=0.
  - A tick counter counts 0..TICK_CYC-1. PLAY lasts exactly dur×TICK_CYC cycles.
  - Then go to GAP, or straight to next-slot handling if `GAP_CYC`=0.
- **GAP**: `buzz`=0 for `GAP_CYC` cycles, then next-slot handling.
- **Next-slot handling**
  - idx < SEQ_LEN-1: idx++, go to FETCH.
  - Otherwise go to end-handling.
- **End-handling**
  - `loop_en`=1: idx=0, go to FETCH, no `done`.
  - Otherwise pulse `done` for one cycle and go to IDLE.
- **stop**: in any non-IDLE state, `stop`=1 forces IDLE on the next edge, with `buzz`=0 and no `done`.
- **level_sel** changes while playing are ignored; `rom_addr` keeps the latched level.
- **Counters**
  - Phase: DIV_W bits. Duration: DUR_W bits. Tick: clog2(TICK_CYC) bits.
  - All counters wrap by compare-reset, never by overflow.

## Timing
- **Reset**: async; the state goes to IDLE immediately.
  - `buzz`=0, `playing`=0, `done`=0, `rom_addr`=0, `note_idx`=0.
  - Reset mid-tune aborts the tune with no `done`.
- **Start latency**: `start` sampled at edge N gives FETCH in cycle N+1, WAIT in N+2, and the first `buzz` high in N+3.
- **Per-note overhead**: 2 cycles (FETCH+WAIT) plus `GAP_CYC`.
- **done**: asserted in the cycle after the terminating WAIT or slot; `playing` is 0 in that same cycle.
- **ROM**: `rom_addr` is registered and held stable through WAIT. `rom_data` is required exactly one cycle after the address.

## Test plan
Parameters for all tests: `NUM_LEVELS`=4, `SEQ_LEN`=8, `TICK_CYC`=4, `GAP_CYC`=2.

1. Reset asserted mid-PLAY -> all outputs 0 immediately; after `rst_n`=1 the FSM stays IDLE until `start`.
2. `level_sel`=2, slot0={hp=3,dur=2}, slot1={x,dur=0}, `start` at edge 0:
   - `rom_addr`=16 in cycle 1.
   - `buzz` 1,1,1,0,0,0,1,1 over cycles 3–10; `buzz`=0 in cycles 11–12.
   - `rom_addr`=17 in cycle 13.
   - `done` pulse in cycle 15; `playing`=0 from cycle 15.
3. Rest slot {hp=0,dur=3} -> `buzz`=0 and `playing`=1 for 12 cycles, then GAP and the next fetch.
4. `level_sel` switched 1→3 during PLAY of slot 2 -> next `rom_addr`=11 (level 1, idx 3). With `NUM_LEVELS`=3, `level_sel`=3 plus `start` -> stays IDLE.
5. `stop` mid-PLAY -> next cycle `buzz`=0, `playing`=0, no `done`. `start` and `stop` together in IDLE -> stays IDLE.
6. `loop_en`=1, all 8 slots {hp=2,dur=1} -> after slot 7 the GAP is followed by `rom_addr` = level×8+0; `done` is never asserted; `note_idx` wraps 7→0.
